// File: rtl/seq_squarer.sv
// Multi-cycle radix-2 shift-add squarer, one operand in flight, valid/ready on both sides.
// Optional SQUARER_SIGNED_IN_EN: two's-complement operand, magnitude squared.
module seq_squarer #(
    parameter int WIDTH = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] data_out,
    output logic               busy
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     m_q, m_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [RW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     dout_q, dout_d;
    logic              ovalid_q, ovalid_d;

    logic [WIDTH-1:0]  operand;
    logic [RW-1:0]     acc_next;
    logic              accept;
    logic              deliver;
    logic              last_iter;

`ifdef SQUARER_SIGNED_IN_EN
    // Most-negative input negates to itself; read unsigned it is 2^(WIDTH-1).
    always_comb begin
        operand = data_in[WIDTH-1] ? (~data_in + WIDTH'(1)) : data_in;
    end
`else
    always_comb begin
        operand = data_in;
    end
`endif

    always_comb begin
        accept    = (state_q == IDLE) && in_valid;
        deliver   = (state_q == DONE) && out_ready;
        last_iter = (state_q == CALC) && (cnt_q == LAST);
        acc_next  = acc_q + (q_q[0] ? m_q : '0);
    end

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            m_q      <= '0;
            q_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            q_q      <= q_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)    state_d = CALC;
            CALC: if (last_iter) state_d = DONE;
            DONE: if (deliver)   state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        m_d      = m_q;
        q_d      = q_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        ovalid_d = ovalid_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    m_d   = RW'(operand);
                    q_d   = operand;
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            CALC: begin
                acc_d = acc_next;
                m_d   = m_q << 1;
                q_d   = q_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    dout_d   = acc_next;
                    ovalid_d = 1'b1;
                end
            end
            DONE: begin
                if (deliver) ovalid_d = 1'b0;
            end
            default: begin
                ovalid_d = 1'b0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = ovalid_q;
        data_out  = dout_q;
    end

endmodule

// File: tb/tb_seq_squarer.sv
// Directed self-checking bench for seq_squarer (WIDTH=24).
// Honours SQUARER_SIGNED_IN_EN for signed-operand expectations.
module tb_seq_squarer;

    localparam int W = 24;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   data_in;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] data_out;
    logic           busy;

    int tests;
    int fails;

    seq_squarer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one operand, wait for the result, take it; returns result and latency
    task automatic run_op(input logic [W-1:0] d, output logic [2*W-1:0] res,
                          output int lat);
        in_valid = 1'b1;
        data_in  = d;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        data_in  = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = data_out;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [2*W-1:0] r;
    logic [2*W-1:0] held;
    logic [2*W-1:0] bres [3];
    int             lat;
    int             acc_t [3];
    int             na;
    int             nr;
    logic           stable;
    logic           blocked;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        data_in = '0;
        tick();
        tick();
        rst_n = 1'b1;

        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_data_out", 64'(data_out), 64'd0);

        run_op(24'h000000, r, lat);
        check("zero_latency", 64'(lat), 64'd24);
        check("zero_result", 64'(r), 64'h0);

        run_op(24'hFFFFFF, r, lat);
`ifdef SQUARER_SIGNED_IN_EN
        check("ffffff_result", 64'(r), 64'h000000000001);
`else
        check("ffffff_result", 64'(r), 64'hFFFFFE000001);
`endif
        check("ffffff_latency", 64'(lat), 64'd24);

        run_op(24'd3000, r, lat);
        check("d3000_result", 64'(r), 64'h000000895440);

        run_op(24'h800000, r, lat);
        check("msb_only_result", 64'(r), 64'h400000000000);

        run_op(24'hFFFFFB, r, lat);
`ifdef SQUARER_SIGNED_IN_EN
        check("neg5_result", 64'(r), 64'h000000000019);
`else
        check("fffffb_result", 64'(r), 64'hFFFFF6000019);
`endif

        run_op(24'h000007, r, lat);
        check("seven_result", 64'(r), 64'h000000000031);

        // Backpressure: result held, new operand refused
        in_valid = 1'b1;
        data_in  = 24'h000005;
        tick();
        data_in = 24'h0000AA;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd24);
        held = data_out;
        check("bp_result", 64'(held), 64'h19);
        stable  = 1'b1;
        blocked = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = W'(i * 17 + 3);
            tick();
            if (data_out !== held || out_valid !== 1'b1) stable = 1'b0;
            if (in_ready !== 1'b0 || busy !== 1'b1) blocked = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_no_accept", 64'(blocked), 64'd1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_data_kept", 64'(data_out), 64'h19);

        // Reset mid-operation
        in_valid = 1'b1;
        data_in  = 24'h123456;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data_out", 64'(data_out), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        nr = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) nr++;
        end
        check("mid_rst_no_pulse", 64'(nr), 64'd0);
        run_op(24'h000002, r, lat);
        check("after_rst_result", 64'(r), 64'h4);
        check("after_rst_latency", 64'(lat), 64'd24);

        // Back-to-back with both handshakes always asserted
        na = 0;
        nr = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        data_in   = 24'd1;
        for (int c = 0; c < 200 && nr < 3; c++) begin
            if (in_ready && in_valid) begin
                acc_t[na] = c;
                na++;
            end
            if (out_valid) begin
                bres[nr] = data_out;
                nr++;
            end
            tick();
            in_valid = (na < 3);
            data_in  = W'(na + 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", 64'(nr), 64'd3);
        check("b2b_accepts", 64'(na), 64'd3);
        check("b2b_res0", 64'(bres[0]), 64'd1);
        check("b2b_res1", 64'(bres[1]), 64'd4);
        check("b2b_res2", 64'(bres[2]), 64'd9);
        check("b2b_gap01", 64'(acc_t[1] - acc_t[0]), 64'd26);
        check("b2b_gap12", 64'(acc_t[2] - acc_t[1]), 64'd26);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
